mem_bus_master: RTL and testbench

//  Initiator side of the picorv32 native memory interface (mem_valid/mem_ready handshake).

---
 rtl/mem_bus_master_if.sv | 42 ++++
 rtl/mem_bus_master.sv | 99 +++++++++
 tb/tb_mem_bus_master.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_master_if.sv
// Bundle of the command, memory-bus and response signals of mem_bus_master.
// The master modport is the bus-master view; slave is the command issuer / memory side.
interface mem_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        cmd_instr;

  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        rsp_misalign;

  modport master (
    input  cmd_valid, cmd_addr, cmd_wdata, cmd_wstrb, cmd_instr,
    output cmd_ready,
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    output rsp_valid, rsp_rdata, rsp_timeout, rsp_misalign,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_wdata, cmd_wstrb, cmd_instr,
    input  cmd_ready,
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    input  rsp_valid, rsp_rdata, rsp_timeout, rsp_misalign,
    output rsp_ready
  );
endinterface

// File: rtl/mem_bus_master.sv
// Initiator for the picorv32 native memory interface: takes one command at a
// time, runs a single mem_valid/mem_ready transaction (with optional timeout),
// and returns read data plus status flags on a valid/ready response port.
module mem_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_bus_master_if.master     bus,
  output logic [CNT_W-1:0]     txn_count
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Timeout fires on the edge that would take the wait counter to TIMEOUT_CYCLES.
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  // Command port is open only in IDLE and never while reset is asserted.
  always_comb begin
    bus.cmd_ready = (state == IDLE) && !reset;
  end

  // Transaction FSM with all bus and response outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      txn_count        <= '0;
      bus.mem_valid    <= 1'b0;
      bus.mem_instr    <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.mem_wstrb    <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_rdata    <= '0;
      bus.rsp_timeout  <= 1'b0;
      bus.rsp_misalign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_addr[1:0] != 2'b00) begin
              // Misaligned: answer directly, the memory bus stays quiet.
              bus.rsp_valid    <= 1'b1;
              bus.rsp_misalign <= 1'b1;
              bus.rsp_rdata    <= '0;
              state            <= RSP;
            end else begin
              bus.mem_valid <= 1'b1;
              bus.mem_addr  <= bus.cmd_addr;
              bus.mem_wdata <= bus.cmd_wdata;
              bus.mem_wstrb <= bus.cmd_wstrb;
              bus.mem_instr <= bus.cmd_instr;
              wait_cnt      <= '0;
              state         <= BUS;
            end
          end
        end
        BUS: begin
          if (bus.mem_ready) begin
            // Ready wins over a coincident timeout.
            bus.mem_valid <= 1'b0;
            bus.rsp_rdata <= (bus.mem_wstrb == 4'b0000) ? bus.mem_rdata : '0;
            bus.rsp_valid <= 1'b1;
            if (txn_count != '1) begin
              txn_count <= txn_count + 1'b1;
            end
            state <= RSP;
          end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST)) begin
            bus.mem_valid   <= 1'b0;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_rdata   <= '0;
            bus.rsp_valid   <= 1'b1;
            state           <= RSP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RSP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid    <= 1'b0;
            bus.rsp_timeout  <= 1'b0;
            bus.rsp_misalign <= 1'b0;
            bus.rsp_rdata    <= '0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed, table-driven bench for mem_bus_master with a small memory responder.
module tb_mem_bus_master;

  localparam int unsigned NEVER = 1000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    logic [31:0] rdata;
    int unsigned ready_wait;
    int unsigned rsp_dly;
    int unsigned exp_cycles;
    logic [31:0] exp_rdata;
    logic        exp_to;
    logic        exp_mis;
    logic [15:0] exp_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] txn_count;
  int          n_cmp = 0;
  int          n_err = 0;

  mem_bus_master_if bus ();

  mem_bus_master #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
    input logic instr, input logic [31:0] rdata, input int unsigned ready_wait,
    input int unsigned rsp_dly, input int unsigned exp_cycles,
    input logic [31:0] exp_rdata, input logic exp_to, input logic exp_mis,
    input logic [15:0] exp_cnt);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.instr = instr;
    v.rdata = rdata; v.ready_wait = ready_wait; v.rsp_dly = rsp_dly;
    v.exp_cycles = exp_cycles; v.exp_rdata = exp_rdata; v.exp_to = exp_to;
    v.exp_mis = exp_mis; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  // Issues one command at a negedge and follows it through bus and response phases.
  task automatic run_vec(input vec_t v);
    int unsigned cycles;
    int unsigned guard;
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.cmd_wstrb = v.wstrb;
    bus.cmd_instr = v.instr;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    cycles = 0;
    guard  = 0;
    while (bus.mem_valid === 1'b1 && guard < 64) begin
      cycles++;
      chk("mem_addr",  bus.mem_addr, v.addr);
      chk("mem_wdata", bus.mem_wdata, v.wdata);
      chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(v.wstrb));
      chk("mem_instr", 32'(bus.mem_instr), 32'(v.instr));
      chk("cmd_ready_bus", 32'(bus.cmd_ready), 32'd0);
      bus.mem_ready = (cycles > v.ready_wait);
      bus.mem_rdata = v.rdata;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      guard++;
    end
    chk("bus_bound", 32'(guard < 64), 32'd1);
    chk("valid_cycles", cycles, v.exp_cycles);
    chk("rsp_valid_up", 32'(bus.rsp_valid), 32'd1);
    for (int unsigned i = 0; i < v.rsp_dly; i++) begin
      chk("rsp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_hold_rdata", bus.rsp_rdata, v.exp_rdata);
      chk("cmd_ready_rsp", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
    end
    chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(v.exp_to));
    chk("rsp_misalign", 32'(bus.rsp_misalign), 32'(v.exp_mis));
    chk("mem_valid_rsp", 32'(bus.mem_valid), 32'd0);
    chk("cmd_ready_hs", 32'(bus.cmd_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_down", 32'(bus.rsp_valid), 32'd0);
    chk("rsp_flags_clr", 32'({bus.rsp_timeout, bus.rsp_misalign}), 32'd0);
    chk("cmd_ready_next", 32'(bus.cmd_ready), 32'd1);
    chk("txn_count", 32'(txn_count), 32'(v.exp_cnt));
  endtask

  vec_t vecs[8];

  initial begin
    // addr, wdata, wstrb, instr, mem_rdata, ready_wait, rsp_dly, cycles, rdata, to, mis, cnt
    vecs[0] = mk(32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'hCAFEF00D, 0, 0, 1, 32'h0, 1'b0, 1'b0, 16'd1);
    vecs[1] = mk(32'h100, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 3, 0, 4, 32'hDEADBEEF, 1'b0, 1'b0, 16'd2);
    vecs[2] = mk(32'h102, 32'h0,        4'h0, 1'b0, 32'h11111111, 0, 0, 0, 32'h0, 1'b0, 1'b1, 16'd2);
    vecs[3] = mk(32'h200, 32'h0,        4'h0, 1'b0, 32'h22222222, NEVER, 0, 16, 32'h0, 1'b1, 1'b0, 16'd2);
    vecs[4] = mk(32'h204, 32'h0,        4'h0, 1'b1, 32'h0BADC0DE, 15, 0, 16, 32'h0BADC0DE, 1'b0, 1'b0, 16'd3);
    vecs[5] = mk(32'h300, 32'h0,        4'h0, 1'b0, 32'h55AA55AA, 1, 5, 2, 32'h55AA55AA, 1'b0, 1'b0, 16'd4);
    vecs[6] = mk(32'h301, 32'hFFFF0000, 4'h3, 1'b0, 32'h33333333, 0, 2, 0, 32'h0, 1'b0, 1'b1, 16'd4);
    vecs[7] = mk(32'h010, 32'h0000AB00, 4'h2, 1'b0, 32'h44444444, 2, 0, 3, 32'h0, 1'b0, 1'b0, 16'd5);

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_wstrb = '0;
    bus.cmd_instr = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_txn_count", 32'(txn_count), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Stray mem_ready with no request pending must not count or respond.
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("stray_ready_cnt", 32'(txn_count), 32'd0);
    chk("stray_ready_rsp", 32'(bus.rsp_valid), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // Reset while waiting on the bus drops the transaction.
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h400;
    bus.cmd_wstrb = 4'h0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", 32'(bus.mem_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("midrst_txn_count", 32'(txn_count), 32'd0);
    chk("midrst_mem_addr", bus.mem_addr, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run_vec(mk(32'h100, 32'h600DF00D, 4'hF, 1'b0, 32'h0, 0, 0, 1, 32'h0, 1'b0, 1'b0, 16'd1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
